// File: rtl/mem_pkg.sv
// Shared definitions for the memory access sequencer.
//   F3_*              RISC-V funct3 size/sign codes for loads and stores
//   state_t           sequencer state encoding
//   size_from_funct3  byte count of a request (1, 2 or 4), or 0 if illegal
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_READ_LAST,
    ST_DONE
  } state_t;

  // Unsigned sizes only exist for loads, so they are illegal as stores.
  function automatic logic [2:0] size_from_funct3(input logic       is_write,
                                                  input logic [2:0] funct3);
    logic [2:0] n;
    n = 3'd0;
    case (funct3)
      F3_B:    n = 3'd1;
      F3_H:    n = 3'd2;
      F3_W:    n = 3'd4;
      F3_BU:   n = is_write ? 3'd0 : 3'd1;
      F3_HU:   n = is_write ? 3'd0 : 3'd2;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/memory_access_sequencer.sv
// Memory access sequencer: turns one 32-bit load/store request into 1, 2 or 4
// little-endian single-byte accesses on a 2**ADDR_WIDTH x 8 memory, and
// assembles and sign/zero-extends load data.
//   clk, reset                      clock, asynchronous active-high reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_write, req_funct3           store/load and size/sign code
//   req_addr, req_wdata             address of the low byte, store data
//   resp_valid                      one-cycle completion pulse
//   resp_rdata, resp_error          load result (0 for stores/errors), illegal funct3
//   mem_write_enable, mem_address,
//   mem_data_in, mem_data_out       byte memory port (read data registered, 1-cycle)
module memory_access_sequencer
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [7:0]            mem_data_in,
  input  logic [7:0]            mem_data_out
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [2:0]            funct3_q;
  logic [1:0]            last_q;    // index of the final byte (n-1)
  logic [1:0]            idx_q;     // byte index k currently on the memory port
  logic                  err_q;
  logic [31:0]           asm_q;     // load assembly register

  logic [2:0]  req_size;
  logic        accept;
  logic [1:0]  idx_nxt;
  logic [31:0] asm_full;
  logic [31:0] load_result;

  assign req_size = size_from_funct3(req_write, req_funct3);
  assign accept   = req_valid && req_ready;
  assign idx_nxt  = idx_q + 2'd1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_size == 3'd0) state_d = ST_DONE;
          else if (req_write)   state_d = ST_WRITE;
          else                  state_d = ST_READ;
        end
      end
      ST_WRITE:     if (idx_q == last_q) state_d = ST_DONE;
      ST_READ:      if (idx_q == last_q) state_d = ST_READ_LAST;
      ST_READ_LAST: state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_DONE);
    resp_error = (state_q == ST_DONE) && err_q;
  end

  // ---------------------------------------------------------------------------
  // Load result: the final byte arrives on mem_data_out during READ_LAST, so
  // merge it combinationally and extend before registering into resp_rdata.
  // ---------------------------------------------------------------------------
  always_comb begin
    asm_full = asm_q;
    asm_full[{last_q, 3'b000} +: 8] = mem_data_out;
  end

  always_comb begin
    case (funct3_q)
      F3_B:    load_result = {{24{asm_full[7]}},  asm_full[7:0]};
      F3_H:    load_result = {{16{asm_full[15]}}, asm_full[15:0]};
      F3_BU:   load_result = {24'd0, asm_full[7:0]};
      F3_HU:   load_result = {16'd0, asm_full[15:0]};
      default: load_result = asm_full;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered memory-port outputs. The memory port is driven
  // from registers so address/data are stable for the whole access cycle and
  // mem_address simply holds its last value while idle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q           <= '0;
      wdata_q          <= '0;
      funct3_q         <= '0;
      last_q           <= '0;
      idx_q            <= '0;
      err_q            <= 1'b0;
      asm_q            <= '0;
      resp_rdata       <= '0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_data_in      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            last_q   <= 2'(req_size - 3'd1);
            idx_q    <= '0;
            asm_q    <= '0;
            err_q    <= (req_size == 3'd0);
            if (req_size == 3'd0) begin
              // Illegal request: leave the memory port untouched.
              resp_rdata <= '0;
            end else begin
              mem_address      <= req_addr;
              mem_write_enable <= req_write;
              if (req_write) mem_data_in <= req_wdata[7:0];
            end
          end
        end

        ST_WRITE: begin
          if (idx_q == last_q) begin
            mem_write_enable <= 1'b0;
            resp_rdata       <= '0;
          end else begin
            idx_q       <= idx_nxt;
            mem_address <= addr_q + ADDR_WIDTH'(idx_nxt);
            mem_data_in <= wdata_q[{idx_nxt, 3'b000} +: 8];
          end
        end

        ST_READ: begin
          // Data for byte k-1 is on mem_data_out while byte k is addressed.
          if (idx_q != 2'd0) asm_q[{idx_q - 2'd1, 3'b000} +: 8] <= mem_data_out;
          if (idx_q != last_q) begin
            idx_q       <= idx_nxt;
            mem_address <= addr_q + ADDR_WIDTH'(idx_nxt);
          end
        end

        ST_READ_LAST: resp_rdata <= load_result;

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Self-checking bench for memory_access_sequencer with a behavioural 1024 x 8
// registered-read memory attached to the memory port.
module tb_memory_access_sequencer;
  import mem_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_error;
  logic          mem_write_enable;
  logic [AW-1:0] mem_address;
  logic [7:0]    mem_data_in;
  logic [7:0]    mem_data_out = 8'd0;

  always #5 clk = ~clk;

  memory_access_sequencer #(.ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in),
    .mem_data_out     (mem_data_out)
  );

  // Behavioural memory: read data registered, valid the cycle after the address.
  logic [7:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address] <= mem_data_in;
    mem_data_out <= mem[mem_address];
  end

  function automatic logic [7:0] init_byte(input int a);
    return 8'(a) ^ 8'hA5;
  endfunction

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard of expected responses.
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } resp_t;
  resp_t sb_q[$];

  always @(negedge clk) begin : monitor
    resp_t e;
    if (!reset && resp_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_rdata"}, resp_rdata, e.rdata);
        check({e.name, "_err"}, 32'(resp_error), 32'(e.err));
      end
    end
  end

  typedef struct {
    logic          wr;
    logic [2:0]    f3;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp_rdata;
    logic          exp_err;
    int            lat;     // cycles from acceptance edge to resp_valid
    string         name;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic wr, input logic [2:0] f3, input logic [AW-1:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input logic exp_err, input int lat, input string name);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.lat = lat; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic run_req(input vec_t v);
    logic [AW-1:0] addr_before;
    int  cyc;
    bit  quiet;
    resp_t e;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    addr_before = mem_address;
    @(posedge clk);
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.name = v.name;
    sb_q.push_back(e);
    #1;
    // Scramble the request inputs: the DUT must use its latched copy.
    req_valid  = 1'b0;
    req_wdata  = ~v.wdata;
    req_addr   = v.addr + 10'd5;
    req_funct3 = ~v.f3;
    cyc   = 0;
    quiet = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      if (mem_write_enable || mem_address !== addr_before) quiet = 1'b0;
    end while (!resp_valid && cyc < 20);
    check({v.name, "_latency"}, 32'(cyc), 32'(v.lat));
    check({v.name, "_ready_in_done"}, 32'(req_ready), 32'd0);
    if (v.exp_err) check({v.name, "_no_mem_activity"}, 32'(quiet), 32'd1);
    @(negedge clk);
    check({v.name, "_pulse_end"}, {30'd0, resp_valid, req_ready}, 32'b01);
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 1024; i++) mem[i] = init_byte(i);

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;

    #1;
    check("reset_outputs",
          {resp_rdata[15:0], 8'(mem_address), mem_data_in},
          32'd0);
    check("reset_ctrl", {28'd0, req_ready, resp_valid, resp_error, mem_write_enable}, 32'b1000);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    //   wr    f3     addr     wdata          rdata          err lat name
    add(1'b1, F3_W,  10'h010, 32'hDEADBEEF, 32'h00000000, 0, 5, "sw_010");
    add(1'b0, F3_W,  10'h010, 32'h0,        32'hDEADBEEF, 0, 6, "lw_010");
    add(1'b1, F3_B,  10'h020, 32'h00000080, 32'h00000000, 0, 2, "sb_020");
    add(1'b0, F3_B,  10'h020, 32'h0,        32'hFFFFFF80, 0, 3, "lb_020");
    add(1'b0, F3_BU, 10'h020, 32'h0,        32'h00000080, 0, 3, "lbu_020");
    add(1'b1, F3_H,  10'h3FF, 32'h00001234, 32'h00000000, 0, 3, "sh_3ff");
    add(1'b0, F3_HU, 10'h3FF, 32'h0,        32'h00001234, 0, 4, "lhu_3ff");
    add(1'b1, F3_H,  10'h100, 32'h00008001, 32'h00000000, 0, 3, "sh_100");
    add(1'b0, F3_H,  10'h100, 32'h0,        32'hFFFF8001, 0, 4, "lh_100");
    add(1'b0, F3_HU, 10'h100, 32'h0,        32'h00008001, 0, 4, "lhu_100");
    add(1'b0, 3'b011, 10'h050, 32'h0,       32'h00000000, 1, 1, "ld_f3_011");
    add(1'b1, 3'b100, 10'h200, 32'h00000055, 32'h00000000, 1, 1, "st_f3_100");
    add(1'b0, 3'b111, 10'h060, 32'h0,       32'h00000000, 1, 1, "ld_f3_111");
    add(1'b0, F3_W,  10'h011, 32'h0,        32'hB1DEADBE, 0, 6, "lw_011_misaligned");
    add(1'b0, F3_B,  10'h010, 32'h0,        32'hFFFFFFEF, 0, 3, "lb_010");

    foreach (vecs[i]) run_req(vecs[i]);

    check("mem_010_013", {mem[10'h013], mem[10'h012], mem[10'h011], mem[10'h010]}, 32'hDEADBEEF);
    check("mem_wrap", {16'd0, mem[10'h000], mem[10'h3FF]}, 32'h00001234);
    check("mem_200_untouched", 32'(mem[10'h200]), 32'(8'hA5));

    // Reset during the third write cycle of SW 0x040.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_W;
    req_addr = 10'h040; req_wdata = 32'h11223344;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pre_addr", {22'd0, mem_address}, 32'h042);
    reset = 1'b1;
    #1;
    check("rst_async_data", resp_rdata, 32'd0);
    check("rst_async_port", {12'd0, 2'(mem_address), mem_data_in,
                             req_ready, resp_valid, resp_error, mem_write_enable},
          {12'd0, 2'd0, 8'd0, 4'b1000});
    check("rst_async_addr", {22'd0, mem_address}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_mem_040_043", {mem[10'h043], mem[10'h042], mem[10'h041], mem[10'h040]},
          {init_byte(32'h43), init_byte(32'h42), 8'h33, 8'h44});
    check("rst_no_pending", 32'(sb_q.size()), 32'd0);

    // Back-to-back with req_valid held: SW then LW of the same word.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_W;
    req_addr = 10'h080; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    sb_q.push_back('{rdata: 32'h0, err: 1'b0, name: "b2b_sw"});
    #1;
    req_write = 1'b0; req_wdata = 32'h0BAD0BAD;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!req_ready && cnt < 20);
    check("b2b_spacing", 32'(cnt), 32'd6);
    @(posedge clk);
    sb_q.push_back('{rdata: 32'hCAFEF00D, err: 1'b0, name: "b2b_lw"});
    #1 req_valid = 1'b0;
    cnt = 0;
    while (sb_q.size() != 0 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("b2b_drained", 32'(sb_q.size()), 32'd0);
    check("b2b_mem", {mem[10'h083], mem[10'h082], mem[10'h081], mem[10'h080]}, 32'hCAFEF00D);

    repeat (3) @(negedge clk);
    check("final_scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
